// File: rtl/best_pkg.sv
// Shared definitions for the best-track readout: word geometry, header layout,
// request record and FSM encoding.
package best_pkg;

  localparam int BEST_W  = 36;
  localparam int BEST_AW = 8;

  localparam logic [3:0] HDR_MARK = 4'hA;

  localparam int HDR_MARK_LSB  = 32;
  localparam int HDR_NUM_LSB   = 20;
  localparam int HDR_START_LSB = 12;
  localparam int HDR_LEN_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_t;

  typedef struct packed {
    logic [11:0]        num;
    logic [BEST_AW-1:0] start;
    logic [BEST_AW-1:0] len;
  } req_t;

  function automatic logic [BEST_W-1:0] make_hdr(input req_t r);
    logic [BEST_W-1:0] w;
    w = '0;
    w[HDR_MARK_LSB  +: 4]       = HDR_MARK;
    w[HDR_NUM_LSB   +: 12]      = r.num;
    w[HDR_START_LSB +: BEST_AW] = r.start;
    w[HDR_LEN_LSB   +: BEST_AW] = r.len;
    return w;
  endfunction

endpackage

// File: rtl/best_skid.sv
// Two-entry skid buffer between the memory read port and the DAQ output.
// The output word is always taken from a register.
module best_skid
  import best_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BEST_W-1:0] in_data,
  input  logic              in_last,
  output logic [BEST_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        level
);

  logic [BEST_W-1:0] d0, d1;
  logic              l0, l1;
  logic [1:0]        cnt;
  logic              push, pop;

  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((cnt != 2'd2) || pop);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = d0;
  assign out_last  = l0;
  assign level     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      cnt <= '0;
    end else begin
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      // A push lands in slot 0 whenever slot 0 is (or is becoming) free.
      if (push) begin
        if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
          d0 <= in_data;
          l0 <= in_last;
        end else begin
          d1 <= in_data;
          l1 <= in_last;
        end
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/best_readout.sv
// Read-side controller for the best-track ring memory: queues L1A windows,
// streams header + window data to the DAQ and protects pending windows via adb.
module best_readout
  import best_pkg::*;
#(
  parameter int L1A_DELAY = 100,
  parameter int QDEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BEST_AW-1:0] adw,
  input  logic [BEST_AW-1:0] wblock,
  input  logic               l1a,
  output logic [BEST_AW-1:0] adr,
  input  logic [BEST_W-1:0]  dr,
  output logic [BEST_AW-1:0] adb,
  output logic [BEST_W-1:0]  dout,
  output logic               dout_valid,
  output logic               dout_last,
  input  logic               dout_ready,
  output logic               busy,
  output logic               overflow,
  output logic [11:0]        l1a_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [BEST_AW-1:0] DLY = BEST_AW'(L1A_DELAY);

  req_t          q [QDEPTH];
  logic [PW-1:0] wp, rp, rp_next;
  logic [PW:0]   qcnt, qleft;
  logic          q_empty, q_full, push_q, pop_q;
  req_t          head;

  state_t state, state_n;

  logic [BEST_AW-1:0] rd_off;
  logic               rd_valid, rd_last;
  logic               acc, hdr_push, issue;
  logic [1:0]         level;
  logic [2:0]         occ, room;

  logic              sk_valid, sk_last;
  logic [BEST_W-1:0] sk_data;

  assign q_empty = (qcnt == '0);
  assign q_full  = (qcnt == (PW+1)'(QDEPTH));
  assign head    = q[rp];
  assign acc     = dout_valid && dout_ready;
  assign push_q  = l1a && !q_full;
  assign pop_q   = acc && dout_last && (state != ST_IDLE);
  assign rp_next = rp + PW'(pop_q);
  assign qleft   = qcnt - (PW+1)'(pop_q);

  assign hdr_push = (state == ST_IDLE) && !q_empty;

  // Occupancy counts this cycle's header push and output pop so that a read
  // can be issued every cycle while the output drains at full rate.
  assign occ   = {1'b0, level} + {2'b0, rd_valid} + {2'b0, hdr_push};
  assign room  = 3'd2 + {2'b0, acc};
  assign issue = !q_empty && (rd_off < head.len) && (occ < room);

  assign adr  = head.start + rd_off;
  assign busy = !q_empty || (state != ST_IDLE);

  assign sk_valid = hdr_push || rd_valid;
  assign sk_data  = hdr_push ? make_hdr(head) : dr;
  assign sk_last  = hdr_push ? (head.len == '0) : rd_last;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (!q_empty) state_n = ST_HDR;
      ST_HDR:  if (acc) state_n = dout_last ? ST_IDLE : ST_DATA;
      ST_DATA: if (acc && dout_last) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wp       <= '0;
      rp       <= '0;
      qcnt     <= '0;
      rd_off   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      adb      <= '0;
      overflow <= 1'b0;
      l1a_cnt  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else begin
      state <= state_n;
      if (push_q) begin
        q[wp] <= '{num: l1a_cnt, start: adw - DLY, len: wblock};
        wp    <= wp + PW'(1);
      end
      rp   <= rp_next;
      qcnt <= qcnt + (PW+1)'(push_q) - (PW+1)'(pop_q);
      if (l1a) begin
        l1a_cnt <= l1a_cnt + 12'd1;
        if (q_full) overflow <= 1'b1;
      end
      if (pop_q)      rd_off <= '0;
      else if (issue) rd_off <= rd_off + 8'd1;
      rd_valid <= issue;
      rd_last  <= issue && ((rd_off + 8'd1) == head.len);
      // Protect the head window as seen after this cycle's push/pop.
      adb <= (qleft == '0) ? (adw - DLY) : q[rp_next].start;
    end
  end

  best_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sk_valid),
    .in_data   (sk_data),
    .in_last   (sk_last),
    .out_data  (dout),
    .out_last  (dout_last),
    .out_valid (dout_valid),
    .out_ready (dout_ready),
    .level     (level)
  );

endmodule

// File: tb/tb_best_readout.sv
// Scoreboard bench for best_readout: a behavioural registered memory feeds dr,
// stimulus queues expected frames, a negedge monitor checks every accepted word.
module tb_best_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adw = '0;
  logic [7:0]  wblock = '0;
  logic        l1a = 1'b0;
  logic [7:0]  adr;
  logic [35:0] dr = '0;
  logic [7:0]  adb;
  logic [35:0] dout;
  logic        dout_valid, dout_last;
  logic        dout_ready = 1'b1;
  logic        busy, overflow;
  logic [11:0] l1a_cnt;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;
  int ndeliv = 0;
  logic [11:0] exp_num = '0;

  typedef struct {
    logic [35:0] d;
    logic        l;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  best_readout #(.L1A_DELAY(100), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .adw(adw), .wblock(wblock), .l1a(l1a),
    .adr(adr), .dr(dr), .adb(adb), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .busy(busy),
    .overflow(overflow), .l1a_cnt(l1a_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h3C, 4'h9, a + 8'd1};
  endfunction

  always @(posedge clk) dr <= pat(adr);

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready driver: always high, or 1-0-1-0 followed by random stalls.
  int tog = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 0) begin
      tog = 0;
      dout_ready = 1'b1;
    end else begin
      dout_ready = (tog < 8) ? (tog % 2 == 0) : ($urandom_range(0, 2) != 0);
      tog++;
    end
  end

  logic        prev_stall = 1'b0;
  logic [35:0] prev_d = '0;
  logic        prev_l = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 36'(dout_valid), 36'd1);
        chk("hold_data", dout, prev_d);
        chk("hold_last", 36'(dout_last), 36'(prev_l));
      end
      if (dout_valid && dout_ready) begin
        ndeliv++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", dout);
        end else begin
          e = sb.pop_front();
          chk("word", dout, e.d);
          chk("last", 36'(dout_last), 36'(e.l));
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout;
      prev_l = dout_last;
    end
  end

  task automatic pulse(input logic [7:0] a, input logic [7:0] n, input bit accept);
    logic [7:0] st;
    st = a - 8'd100;
    @(posedge clk); #1;
    adw = a;
    wblock = n;
    l1a = 1'b1;
    if (accept) begin
      sb.push_back('{{4'hA, exp_num, st, n, 4'h0}, (n == 8'd0)});
      for (int i = 0; i < int'(n); i++)
        sb.push_back('{pat(st + 8'(i)), (i == int'(n) - 1)});
    end
    exp_num++;
    @(posedge clk); #1;
    l1a = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int c;
    c = 0;
    while (busy && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy=1 after %0d cycles, required 0", name, maxc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_num = '0;
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 36'(dout_valid), 36'd0);
    chk("rst_last", 36'(dout_last), 36'd0);
    chk("rst_dout", dout, 36'd0);
    chk("rst_adr", 36'(adr), 36'd0);
    chk("rst_adb", 36'(adb), 36'd0);
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_ovf", 36'(overflow), 36'd0);
    chk("rst_cnt", 36'(l1a_cnt), 36'd0);
    rst = 1'b0;

    // Basic frame at adw=0x10: window starts at 0xAC
    pulse(8'h10, 8'd4, 1'b1);
    chk("t1_adr", 36'(adr), 36'hAC);
    chk("t1_busy", 36'(busy), 36'd1);
    chk("t1_adb", 36'(adb), 36'hAC);
    @(posedge clk); #1;
    chk("t2_hdr_valid", 36'(dout_valid), 36'd1);
    chk("t2_hdr_word", dout, 36'hA000AC040);
    wait_idle("basic_idle", 100);
    chk("basic_adb_idle", 36'(adb), 36'hAC);
    chk("basic_cnt", 36'(l1a_cnt), 36'd1);

    // Wrap around the top of the ring
    pulse(8'h62, 8'd4, 1'b1);
    chk("wrap_adr0", 36'(adr), 36'hFE);
    @(posedge clk); #1;
    chk("wrap_adr1", 36'(adr), 36'hFF);
    @(posedge clk); #1;
    chk("wrap_adr2", 36'(adr), 36'h00);
    @(posedge clk); #1;
    chk("wrap_adr3", 36'(adr), 36'h01);
    wait_idle("wrap_idle", 100);

    // Backpressure through a 20-word window
    rmode = 1;
    d0 = ndeliv;
    pulse(8'h20, 8'd20, 1'b1);
    wait_idle("stall_idle", 400);
    rmode = 0;
    chk("stall_count", 36'(ndeliv - d0), 36'd21);
    chk("stall_sb_empty", 36'(sb.size()), 36'd0);

    // Queue overflow: fifth request dropped
    do_reset();
    pulse(8'h40, 8'd30, 1'b1);
    pulse(8'h48, 8'd30, 1'b1);
    pulse(8'h50, 8'd30, 1'b1);
    pulse(8'h58, 8'd30, 1'b1);
    chk("ovf_before", 36'(overflow), 36'd0);
    pulse(8'h60, 8'd30, 1'b0);
    chk("ovf_after", 36'(overflow), 36'd1);
    wait_idle("ovf_idle", 400);
    chk("ovf_cnt", 36'(l1a_cnt), 36'd5);
    chk("ovf_sb_empty", 36'(sb.size()), 36'd0);

    // Zero-length window: header only, carrying last
    pulse(8'h30, 8'd0, 1'b1);
    @(posedge clk); #1;
    chk("zero_valid", 36'(dout_valid), 36'd1);
    chk("zero_last", 36'(dout_last), 36'd1);
    wait_idle("zero_idle", 50);
    chk("zero_adb", 36'(adb), 36'hCC);
    chk("zero_sb_empty", 36'(sb.size()), 36'd0);

    // Reset in the middle of a frame, then a fresh frame
    pulse(8'h50, 8'd10, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    do_reset();
    chk("mrst_valid", 36'(dout_valid), 36'd0);
    chk("mrst_busy", 36'(busy), 36'd0);
    chk("mrst_adb", 36'(adb), 36'd0);
    chk("mrst_ovf", 36'(overflow), 36'd0);
    chk("mrst_cnt", 36'(l1a_cnt), 36'd0);
    pulse(8'h55, 8'd10, 1'b1);
    wait_idle("mrst_idle", 100);
    chk("mrst_sb_empty", 36'(sb.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
